// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo_arb buffer scheduler: owner encoding,
// FSM state type, default data width and one-hot/owner conversion helpers.
package fifo_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] OWN_W0   = 2'd0;
  localparam logic [1:0] OWN_W1   = 2'd1;
  localparam logic [1:0] OWN_RD   = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Owner code to one-hot grant vector {RD, W1, W0}; NONE maps to zero.
  function automatic logic [2:0] own2oh(input logic [1:0] own);
    logic [2:0] oh;
    oh = 3'b000;
    case (own)
      OWN_W0:  oh = 3'b001;
      OWN_W1:  oh = 3'b010;
      OWN_RD:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // One-hot grant vector {RD, W1, W0} to owner code; zero maps to NONE.
  function automatic logic [1:0] oh2own(input logic [2:0] oh);
    logic [1:0] own;
    own = OWN_NONE;
    if (oh[0])      own = OWN_W0;
    else if (oh[1]) own = OWN_W1;
    else if (oh[2]) own = OWN_RD;
    return own;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational 3-way rotating-priority picker (order W0 -> W1 -> RD),
// starting with the requester after the last owner.
// Ports:
//   elig - eligible vector {RD, W1, W0}
//   last - last owner code (NONE behaves like RD, so W0 goes first)
//   gnt  - one-hot grant {RD, W1, W0}, zero when nothing is eligible
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (last)
      OWN_W0: begin
        if (elig[1])      gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      OWN_W1: begin
        if (elig[2])      gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: begin
        if (elig[0])      gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/fifo_arb.sv
// Scheduler sharing one single-command 32-entry buffer between two writers
// and one reader. Grants in bounded bursts, never issues a write to a full
// or a read to an empty buffer, at most one buffer command per cycle.
// Optional macro FIFO_ARB_RD_PRIO_EN: reader gets strict priority over writes.
// Ports:
//   CLK, RESETL                  - clock, async active-low reset
//   W0_VALID/W0_DATA/W0_READY    - writer 0 handshake (READY combinational)
//   W1_VALID/W1_DATA/W1_READY    - writer 1 handshake (READY combinational)
//   RD_REQ/RD_READY              - read request level / combinational grant
//   RD_VALID/RD_DATA             - registered read-valid, data from buffer
//   BUF_REQ/BUF_WRH_RDL/BUF_DATAIN - buffer command (combinational)
//   BUF_DATAOUT/BUF_FULL/BUF_EMPTY - buffer read data and flags
//   OWNER                        - registered owner of previous cycle's grant
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RESETL,
  input  logic              W0_VALID,
  input  logic [DATA_W-1:0] W0_DATA,
  output logic              W0_READY,
  input  logic              W1_VALID,
  input  logic [DATA_W-1:0] W1_DATA,
  output logic              W1_READY,
  input  logic              RD_REQ,
  output logic              RD_READY,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              BUF_REQ,
  output logic              BUF_WRH_RDL,
  output logic [DATA_W-1:0] BUF_DATAIN,
  input  logic [DATA_W-1:0] BUF_DATAOUT,
  input  logic              BUF_FULL,
  input  logic              BUF_EMPTY,
  output logic [1:0]        OWNER
);

  localparam int unsigned CNT_W = 4;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_q;
  logic             rd_valid_q;

  logic [2:0] elig_c, pick_elig_c, pick_c, own_oh_c, gnt_raw_c, gnt_c;
  logic       cont_c;

  assign elig_c = {RD_REQ & ~BUF_EMPTY, W1_VALID & ~BUF_FULL, W0_VALID & ~BUF_FULL};

`ifdef FIFO_ARB_RD_PRIO_EN
  // Reader is handled ahead of rotation; rotation only arbitrates writers.
  assign pick_elig_c = {1'b0, elig_c[1:0]};
`else
  assign pick_elig_c = elig_c;
`endif

  fifo_arb_rr_pick u_pick (
    .elig (pick_elig_c),
    .last (last_q),
    .gnt  (pick_c)
  );

  // In BURST last_q is the current owner, so it doubles as the burst owner.
  assign own_oh_c = own2oh(last_q);
  assign cont_c   = (state_q == BURST) && (|(elig_c & own_oh_c)) &&
                    (cnt_q < CNT_W'(MAX_BURST));

  // Next-state and grant selection.
  always_comb begin
    gnt_raw_c = 3'b000;
    state_d   = IDLE;
    cnt_d     = '0;
`ifdef FIFO_ARB_RD_PRIO_EN
    if (elig_c[2]) begin
      gnt_raw_c = 3'b100;
      state_d   = BURST;
      cnt_d     = (cont_c && (last_q == OWN_RD)) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end else
`endif
    if (cont_c) begin
      gnt_raw_c = own_oh_c;
      state_d   = BURST;
      cnt_d     = cnt_q + CNT_W'(1);
    end else if (|pick_elig_c) begin
      gnt_raw_c = pick_c;
      state_d   = BURST;
      cnt_d     = CNT_W'(1);
    end
    last_d = (|gnt_raw_c) ? oh2own(gnt_raw_c) : last_q;
  end

  // Reset must silence the buffer immediately, even between clock edges.
  assign gnt_c = gnt_raw_c & {3{RESETL}};

  assign W0_READY    = gnt_c[0];
  assign W1_READY    = gnt_c[1];
  assign RD_READY    = gnt_c[2];
  assign BUF_REQ     = |gnt_c;
  assign BUF_WRH_RDL = gnt_c[0] | gnt_c[1];
  assign BUF_DATAIN  = gnt_c[0] ? W0_DATA :
                       gnt_c[1] ? W1_DATA : '0;
  assign RD_DATA     = BUF_DATAOUT;
  assign RD_VALID    = rd_valid_q;
  assign OWNER       = owner_q;

  // State, counters and registered status.
  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= OWN_RD;
      owner_q    <= OWN_NONE;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      owner_q    <= (|gnt_c) ? oh2own(gnt_c) : OWN_NONE;
      rd_valid_q <= gnt_c[2];
    end
  end

endmodule

// File: tb/tb_fifo_arb.sv
// Self-checking bench for fifo_arb: a queue-based 32-entry buffer environment
// plus a behavioural scheduler model that predicts every cycle's outputs.
module tb_fifo_arb;

  localparam int unsigned DW    = 32;
  localparam int unsigned MB    = 4;
  localparam int unsigned DEPTH = 32;

  logic          CLK = 1'b0;
  logic          RESETL;
  logic          W0_VALID, W1_VALID, RD_REQ;
  logic [DW-1:0] W0_DATA, W1_DATA, BUF_DATAOUT;
  logic          BUF_FULL, BUF_EMPTY;
  logic          W0_READY, W1_READY, RD_READY, RD_VALID;
  logic          BUF_REQ, BUF_WRH_RDL;
  logic [DW-1:0] RD_DATA, BUF_DATAIN;
  logic [1:0]    OWNER;

  always #5 CLK = ~CLK;

  fifo_arb #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RESETL(RESETL),
    .W0_VALID(W0_VALID), .W0_DATA(W0_DATA), .W0_READY(W0_READY),
    .W1_VALID(W1_VALID), .W1_DATA(W1_DATA), .W1_READY(W1_READY),
    .RD_REQ(RD_REQ), .RD_READY(RD_READY), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .BUF_REQ(BUF_REQ), .BUF_WRH_RDL(BUF_WRH_RDL), .BUF_DATAIN(BUF_DATAIN),
    .BUF_DATAOUT(BUF_DATAOUT), .BUF_FULL(BUF_FULL), .BUF_EMPTY(BUF_EMPTY),
    .OWNER(OWNER)
  );

  int checks   = 0;
  int failures = 0;

  // Buffer environment (obeys whatever command the DUT issues).
  logic [DW-1:0] buf_q[$];
  logic          cmd_req, cmd_wr;
  logic [DW-1:0] cmd_d;

  // Scheduler reference model.
  logic [DW-1:0] mq[$];
  int            m_owner, m_cnt, m_last, m_prev;
  logic          m_rdv;
  logic [DW-1:0] m_rdd;
  int            exp_g;
  logic [DW-1:0] exp_din;
  logic [71:0]   exp_v, obs_v;

  function automatic void model_reset();
    m_owner = -1; m_cnt = 0; m_last = 2; m_prev = 3; m_rdv = 1'b0; m_rdd = '0;
  endfunction

  // Expected grant: -1 none, 0 W0, 1 W1, 2 RD.
  function automatic int model_grant();
    bit e [3];
    if (!RESETL) return -1;
    e[0] = W0_VALID && !BUF_FULL;
    e[1] = W1_VALID && !BUF_FULL;
    e[2] = RD_REQ && !BUF_EMPTY;
`ifdef FIFO_ARB_RD_PRIO_EN
    if (e[2]) return 2;
    e[2] = 1'b0;
`endif
    if (m_owner >= 0 && e[m_owner] && m_cnt < int'(MB)) return m_owner;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_in(input bit v0, input bit v1, input bit r);
    W0_VALID = v0; W1_VALID = v1; RD_REQ = r;
    W0_DATA = $urandom; W1_DATA = $urandom;
  endtask

  // Sample at the falling edge and build observed/expected vectors.
  task automatic eval();
    @(negedge CLK);
    exp_g   = model_grant();
    exp_din = (exp_g == 0) ? W0_DATA : (exp_g == 1) ? W1_DATA : '0;
    exp_v = {exp_g == 0, exp_g == 1, exp_g == 2, exp_g >= 0, (exp_g == 0) || (exp_g == 1),
             exp_din, 2'(m_prev), m_rdv, (m_rdv ? m_rdd : 32'd0)};
    obs_v = {W0_READY, W1_READY, RD_READY, BUF_REQ, BUF_WRH_RDL,
             BUF_DATAIN, OWNER, RD_VALID, (RD_VALID ? RD_DATA : 32'd0)};
    cmd_req = BUF_REQ; cmd_wr = BUF_WRH_RDL; cmd_d = BUF_DATAIN;
  endtask

  // Clock edge: update buffer environment and model, leave inputs to caller.
  task automatic adv();
    @(posedge CLK);
    #1;
    if (cmd_req && cmd_wr && buf_q.size() < DEPTH) buf_q.push_back(cmd_d);
    else if (cmd_req && !cmd_wr && buf_q.size() > 0) BUF_DATAOUT = buf_q.pop_front();
    BUF_FULL  = (buf_q.size() == DEPTH);
    BUF_EMPTY = (buf_q.size() == 0);
    if (RESETL) begin
      m_rdv  = (exp_g == 2);
      m_prev = (exp_g >= 0) ? exp_g : 3;
      if (exp_g == 0 || exp_g == 1) mq.push_back(exp_din);
      if (exp_g == 2 && mq.size() > 0) m_rdd = mq.pop_front();
      if (exp_g < 0) begin
        m_owner = -1; m_cnt = 0;
      end else begin
        m_cnt   = (exp_g == m_owner && m_cnt < int'(MB)) ? m_cnt + 1 : 1;
        m_owner = exp_g;
        m_last  = exp_g;
      end
    end
  endtask

  task automatic test_reset();
    RESETL = 1'b0; model_reset();
    set_in(1, 1, 1);
    eval();
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_hold got=%h exp=%h", obs_v, exp_v); end
    adv();
    RESETL = 1'b1;
    eval();
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_first got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (W0_READY !== 1'b1) begin failures++; $display("FAIL reset_first_w0 got=%b exp=1", W0_READY); end
    adv();
    set_in(0, 0, 0);
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    set_in(0, 0, 1);
    while (!BUF_EMPTY && n < 40) begin
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL drain n=%0d got=%h exp=%h", n, obs_v, exp_v); end
      adv();
      n++;
    end
    checks++;
    if (BUF_EMPTY !== 1'b1) begin failures++; $display("FAIL drain_timeout got=%b exp=1", BUF_EMPTY); end
    set_in(0, 0, 0);
    eval(); adv();
  endtask

  task automatic test_fill();
    int wr;
    wr = 0;
    for (int i = 0; i < 34; i++) begin
      set_in(1, 0, 0);
      W0_DATA = 32'h10 + 32'(i - wr + wr);
      W0_DATA = 32'h10 + 32'(wr);
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL fill i=%0d got=%h exp=%h", i, obs_v, exp_v); end
      if (BUF_FULL) begin
        checks++;
        if (W0_READY !== 1'b0) begin failures++; $display("FAIL fill_full_block got=%b exp=0", W0_READY); end
      end
      if (W0_READY === 1'b1) wr++;
      adv();
    end
    checks++;
    if (wr != 32) begin failures++; $display("FAIL fill_count got=%0d exp=32", wr); end
    set_in(0, 0, 0);
  endtask

  task automatic test_burst_rr();
    for (int i = 0; i < 24; i++) begin
      set_in(1, 1, 0);
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL burst i=%0d got=%h exp=%h", i, obs_v, exp_v); end
      checks++;
      if (W0_READY !== 1'(((i / int'(MB)) % 2) == 0)) begin
        failures++; $display("FAIL burst_seq i=%0d got_w0=%b", i, W0_READY);
      end
      adv();
    end
    set_in(0, 0, 0);
  endtask

  task automatic test_read_two();
    logic [DW-1:0] want [2];
    want[0] = 32'hA; want[1] = 32'hB;
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0);
      W0_DATA = want[i];
      eval(); adv();
    end
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1);
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL read k=%0d got=%h exp=%h", k, obs_v, exp_v); end
      checks++;
      if (RD_READY !== 1'(k < 2)) begin failures++; $display("FAIL read_grant k=%0d got=%b", k, RD_READY); end
      if (k > 0) begin
        checks++;
        if (RD_VALID !== 1'b1 || RD_DATA !== want[k-1]) begin
          failures++; $display("FAIL read_data k=%0d got=%b/%h exp=1/%h", k, RD_VALID, RD_DATA, want[k-1]);
        end
      end
      adv();
    end
    set_in(0, 0, 0);
  endtask

  task automatic test_all3();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 0, 0); eval(); adv();
    end
    for (int i = 0; i < 36; i++) begin
      set_in(1, 1, 1);
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL all3 i=%0d got=%h exp=%h", i, obs_v, exp_v); end
      checks++;
      if ((W0_READY + W1_READY + RD_READY) > 2'd1) begin failures++; $display("FAIL all3_onehot i=%0d", i); end
      adv();
    end
    set_in(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 0); eval(); adv();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 0); eval(); adv();
    end
    set_in(1, 1, 0);
    RESETL = 1'b0; model_reset();
    #1;
    checks++;
    if (W1_READY !== 1'b0 || BUF_REQ !== 1'b0 || OWNER !== 2'd3) begin
      failures++; $display("FAIL reset_mid_async got=%b%b%0d exp=003", W1_READY, BUF_REQ, OWNER);
    end
    eval();
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs_v, exp_v); end
    adv();
    RESETL = 1'b1;
    eval();
    checks++;
    if (obs_v !== exp_v) begin failures++; $display("FAIL reset_mid_rel got=%h exp=%h", obs_v, exp_v); end
    checks++;
    if (W0_READY !== 1'b1 || OWNER !== 2'd3) begin
      failures++; $display("FAIL reset_mid_w0 got=%b/%0d exp=1/3", W0_READY, OWNER);
    end
    adv();
    set_in(0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      eval();
      checks++;
      if (obs_v !== exp_v) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs_v, exp_v); end
      adv();
    end
    set_in(0, 0, 0);
  endtask

  initial begin
    RESETL = 1'b0;
    BUF_FULL = 1'b0; BUF_EMPTY = 1'b1; BUF_DATAOUT = '0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_d = '0; exp_g = -1; exp_din = '0;
    model_reset();
    set_in(0, 0, 0);
    test_reset();
    test_drain();
    test_fill();
    test_drain();
    test_burst_rr();
    test_drain();
    test_read_two();
    test_drain();
    test_all3();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_arb.md
# fifo_arb

Three-way scheduler that shares one single-command 32-entry buffer between two write requesters and one read requester. The buffer accepts at most one operation per cycle, selected by a write-high/read-low command line, so every access goes through this block. It sits between the producer/consumer logic and the buffer instance, issues at most one buffer command per cycle, grants in bounded bursts and never lets an operation reach a full or empty buffer.

## Interface
- DATA_W, 32, data width of all data ports
- MAX_BURST, 4, maximum consecutive grants to one owner (1..15)

- CLK  in  1  clock; all state on rising edge
- RESETL  in  1  asynchronous, active-low reset
- W0_VALID  in  1  writer 0 has data
- W0_DATA  in  DATA_W  writer 0 data
- W0_READY  out  1  writer 0 granted this cycle
- W1_VALID / W1_DATA / W1_READY  same as writer 0, for writer 1
- RD_REQ  in  1  reader requests one word (level, held)
- RD_READY  out  1  read granted this cycle
- RD_VALID  out  1  RD_DATA valid (registered)
- RD_DATA  out  DATA_W  read data, equal to BUF_DATAOUT
- BUF_REQ  out  1  command issued to buffer this cycle
- BUF_WRH_RDL  out  1  1 = write, 0 = read
- BUF_DATAIN  out  DATA_W  write data to buffer
- BUF_DATAOUT  in  DATA_W  buffer read data
- BUF_FULL  in  1  buffer holds 32 words
- BUF_EMPTY  in  1  buffer holds 0 words
- OWNER  out  2  owner of the previous cycle's grant: 0 = W0, 1 = W1, 2 = RD, 3 = none

## Operation
- The eligible set E is evaluated each cycle:
  - W0 is eligible if W0_VALID & !BUF_FULL.
  - W1 is eligible if W1_VALID & !BUF_FULL.
  - RD is eligible if RD_REQ & !BUF_EMPTY.
- State machine:
  - IDLE: no owner.
  - BURST: holds owner o and a 4-bit counter cnt.
- Grant rule:
  - In BURST, if o ∈ E and cnt < MAX_BURST: grant o, cnt++.
  - Otherwise, if E is non-empty: round-robin pick in the order W0→W1→RD, starting after the last owner. The pick becomes the new o, cnt=1, state BURST.
  - If E is empty: no grant, state IDLE. The last-owner pointer is retained.
- At most one READY (or RD_READY) is high per cycle. BUF_REQ = OR of all grants.
- A write grant drives BUF_WRH_RDL=1 and BUF_DATAIN = the winner's data; the transfer completes when VALID&READY.
- A read grant drives BUF_WRH_RDL=0 and BUF_DATAIN=0.
- With no grant: BUF_WRH_RDL=0, BUF_DATAIN=0.
- READY outputs depend combinationally on VALID, BUF_FULL/EMPTY and state. Requesters must not make VALID depend on READY.
- Full/empty are honoured from the buffer flags only. The block relies on one op per cycle, so the flags are always current.

## Timing
- Grant is combinational in cycle t; the buffer updates at the end of t.
- RD_VALID is registered high in t+1 for each read granted in t. RD_DATA is BUF_DATAOUT, valid only while RD_VALID=1.
- OWNER is registered from the grant of cycle t.
- Read-to-RD_VALID latency: 1 cycle. Back-to-back reads give RD_VALID every cycle.
- Reset (RESETL=0, asynchronous):
  - State IDLE, cnt=0, last owner = RD (so W0 has first priority).
  - RD_VALID=0, OWNER=3.
  - All READY, RD_READY and BUF_REQ are forced 0 combinationally while RESETL=0, including mid-burst.
- Burst boundary: when cnt reaches MAX_BURST, the next grant rotates even if the owner is still requesting. If only the owner is eligible, it is re-granted with cnt=1.
- Full while writing: the write grant drops in the same cycle BUF_FULL rises. If RD is eligible, the grant passes to RD.

## Configuration
- FIFO_ARB_RD_PRIO_EN defined: RD has strict priority. If RD ∈ E, RD is granted, preempting any write burst; that write burst ends and rotation resumes from RD. Writes arbitrate round-robin between W0/W1 only when RD is not eligible.
- Undefined: plain three-way burst round-robin as above.

## Structure
- Package fifo_arb_pkg holds:
  - owner encoding constants OWN_W0=0, OWN_W1=1, OWN_RD=2, OWN_NONE=3
  - the state enum (IDLE, BURST)
  - the DATA_W default
- Sub-module fifo_arb_rr_pick: combinational 3-input rotating-priority picker. Inputs are the eligible vector and last owner; output is a one-hot grant.

## Test plan
- Hold RESETL=0 with all requests high → every READY=0, BUF_REQ=0, RD_VALID=0, OWNER=3. Release → first grant goes to W0.
- Hold W0_VALID=1 with data 0x10,0x11,… into an empty buffer → 32 consecutive grants with BUF_WRH_RDL=1. W0_READY drops in the cycle BUF_FULL=1.
- Hold W0 and W1 continuously, buffer not full, MAX_BURST=4 → grant sequence W0×4, W1×4, W0×4, …
- Buffer holds 0xA,0xB; hold RD_REQ 3 cycles → RD_READY in cycles 1–2. RD_VALID in cycles 2–3 with 0xA, 0xB. No grant in cycle 3 (EMPTY).
- All three requesting with the buffer at 16 words:
  - macro undefined → W0×4, W1×4, RD×4 repeating
  - macro defined → RD every cycle until BUF_EMPTY, then W0×4
- Assert RESETL mid-W1 burst (cnt=2) → outputs 0 immediately. After release, the first grant goes to W0 with OWNER=3 for one cycle.
